// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: stall bus encodings, exception codes, FSM states.
package pipe_ctrl_pkg;

  localparam int unsigned STALL_W     = 6;
  localparam int unsigned REFILL_CW   = 4;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  localparam logic [31:0] EXC_INTERRUPT = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL   = 32'h0000_0008;
  localparam logic [31:0] EXC_INST_INV  = 32'h0000_000a;
  localparam logic [31:0] EXC_TRAP      = 32'h0000_000d;
  localparam logic [31:0] EXC_OV        = 32'h0000_000c;
  localparam logic [31:0] EXC_ERET      = 32'h0000_000e;

  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_REFILL = 1'b1
  } state_e;

  function automatic logic [STALL_W-1:0] encode_stall(input logic req_if, input logic req_id,
                                                      input logic req_ex, input logic req_mem);
    if (req_mem)     return STALL_MEM;
    else if (req_ex) return STALL_EX;
    else if (req_id) return STALL_ID;
    else if (req_if) return STALL_IF;
    else             return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipe_ctrl_wdog.sv
// Consecutive-stall counter for the stall watchdog; flags when the count has reached WDOG_LIMIT.
module pipe_ctrl_wdog #(
  parameter int unsigned WDOG_LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_any,
  input  logic flush,
  output logic at_limit
);

  localparam int unsigned W = $clog2(WDOG_LIMIT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign at_limit = (cnt_q == W'(WDOG_LIMIT));

  always_comb begin
    cnt_d = cnt_q;
    if (flush || !stall_any) cnt_d = '0;
    else if (!at_limit)      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall merge, exception flush/redirect, refill guard, stall cycle counter.
// Optional stall watchdog trap enabled by macro PIPE_CTRL_STALL_WATCHDOG_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
  parameter int unsigned REFILL_CYCLES = 2,
  parameter int unsigned WDOG_LIMIT    = 1024,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_from_if,
  input  logic             stallreq_from_id,
  input  logic             stallreq_from_ex,
  input  logic             stallreq_from_mem,
  input  logic [31:0]      excepttype_i,
  input  logic [31:0]      cp0_epc_i,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic             busy_o,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic             wdog_timeout_o
);

  state_e                 state_q, state_d;
  logic [REFILL_CW-1:0]   refill_cnt_q, refill_cnt_d;
  logic [CNT_W-1:0]       stall_cycles_q, stall_cycles_d;

  logic [STALL_W-1:0]     stall_req;
  logic [STALL_W-1:0]     stall_c;
  logic                   flush_c;
  logic [31:0]            new_pc_c;
  logic                   timeout_c;
  logic                   wdog_hit;

  assign stall_req = encode_stall(stallreq_from_if, stallreq_from_id,
                                  stallreq_from_ex, stallreq_from_mem);

`ifdef PIPE_CTRL_STALL_WATCHDOG_EN
  pipe_ctrl_wdog #(
    .WDOG_LIMIT (WDOG_LIMIT)
  ) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .stall_any (stall_c != STALL_NONE),
    .flush     (flush_c),
    .at_limit  (wdog_hit)
  );
`else
  assign wdog_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    refill_cnt_d = refill_cnt_q;
    stall_c      = stall_req;
    flush_c      = 1'b0;
    new_pc_c     = ZERO_WORD;
    timeout_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A real exception outranks a pending watchdog trap, which then simply never fires.
        if (excepttype_i != ZERO_WORD) begin
          flush_c      = 1'b1;
          stall_c      = STALL_NONE;
          new_pc_c     = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
          state_d      = ST_REFILL;
          refill_cnt_d = REFILL_CW'(REFILL_CYCLES - 1);
        end else if (wdog_hit && stall_req != STALL_NONE) begin
          flush_c      = 1'b1;
          stall_c      = STALL_NONE;
          new_pc_c     = EXC_VECTOR;
          timeout_c    = 1'b1;
          state_d      = ST_REFILL;
          refill_cnt_d = REFILL_CW'(REFILL_CYCLES - 1);
        end
      end
      ST_REFILL: begin
        if (refill_cnt_q == '0) state_d = ST_IDLE;
        else                    refill_cnt_d = refill_cnt_q - REFILL_CW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_c[0] == STOP && !(&stall_cycles_q)) stall_cycles_d = stall_cycles_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      refill_cnt_q   <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      refill_cnt_q   <= refill_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // Reset forces all Mealy outputs quiet even though the request inputs may be active.
  assign stall          = rst ? STALL_NONE : stall_c;
  assign flush          = rst ? 1'b0 : flush_c;
  assign new_pc         = rst ? ZERO_WORD : new_pc_c;
  assign wdog_timeout_o = rst ? 1'b0 : timeout_c;
  assign busy_o         = !rst && (state_q != ST_IDLE);
  assign stall_cycles_o = stall_cycles_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios then random traffic against a reference model.
module tb_pipe_ctrl;

  localparam int unsigned LIMIT   = 4;
  localparam int unsigned REFILL  = 2;
  localparam int unsigned CW      = 6;
  localparam int unsigned CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          r_if = 1'b0, r_id = 1'b0, r_ex = 1'b0, r_mem = 1'b0;
  logic [31:0]   exc = '0, epc = '0;
  logic [5:0]    stall;
  logic          flush, busy, tmo;
  logic [31:0]   new_pc;
  logic [CW-1:0] scnt;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  int unsigned m_left  = 0;
  int unsigned m_wd    = 0;
  int unsigned m_scnt  = 0;

  pipe_ctrl #(
    .EXC_VECTOR    (32'h0000_0020),
    .REFILL_CYCLES (REFILL),
    .WDOG_LIMIT    (LIMIT),
    .CNT_W         (CW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .stallreq_from_if  (r_if),
    .stallreq_from_id  (r_id),
    .stallreq_from_ex  (r_ex),
    .stallreq_from_mem (r_mem),
    .excepttype_i      (exc),
    .cp0_epc_i         (epc),
    .stall             (stall),
    .flush             (flush),
    .new_pc            (new_pc),
    .busy_o            (busy),
    .stall_cycles_o    (scnt),
    .wdog_timeout_o    (tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Deepest stalled stage decides how many leading stages freeze.
  function automatic logic [5:0] req_vec(input logic a_if, a_id, a_ex, a_mem);
    int unsigned depth;
    depth = a_mem ? 5 : a_ex ? 4 : a_id ? 3 : a_if ? 2 : 0;
    return 6'((1 << depth) - 1);
  endfunction

  // Called just after a posedge: drive, check at negedge, advance the model, reach next posedge.
  task automatic cycle(input logic a_if, a_id, a_ex, a_mem, input logic [31:0] a_exc, a_epc);
    logic [5:0]  e_stall;
    logic        e_flush, e_tmo, idle, wd_en;
    logic [31:0] e_pc;
    r_if = a_if; r_id = a_id; r_ex = a_ex; r_mem = a_mem; exc = a_exc; epc = a_epc;
    @(negedge clk);
`ifdef PIPE_CTRL_STALL_WATCHDOG_EN
    wd_en = 1'b1;
`else
    wd_en = 1'b0;
`endif
    idle    = (m_left == 0);
    e_stall = req_vec(a_if, a_id, a_ex, a_mem);
    e_flush = 1'b0; e_tmo = 1'b0; e_pc = '0;
    if (idle && a_exc != 0) begin
      e_flush = 1'b1; e_stall = '0;
      e_pc = (a_exc == 32'he) ? a_epc : 32'h20;
    end else if (wd_en && idle && m_wd >= LIMIT && e_stall != 0) begin
      e_flush = 1'b1; e_stall = '0; e_pc = 32'h20; e_tmo = 1'b1;
    end
    chk("stall", 32'(stall), 32'(e_stall));
    chk("flush", 32'(flush), 32'(e_flush));
    chk("new_pc", new_pc, e_pc);
    chk("busy", 32'(busy), 32'(!idle));
    chk("wdog_timeout", 32'(tmo), 32'(e_tmo));
    chk("stall_cycles", 32'(scnt), m_scnt);
    if (e_stall[0] && m_scnt < CNT_MAX) m_scnt++;
    if (idle && e_flush)  m_left = REFILL;
    else if (!idle)       m_left--;
    if (e_flush || e_stall == 0) m_wd = 0;
    else if (m_wd < LIMIT)       m_wd++;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    r_mem = 1'b1; exc = 32'h8; epc = 32'h55;
    rst = 1'b1; #2;
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_new_pc", new_pc, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_tmo", 32'(tmo), 32'h0);
    chk("rst_scnt", 32'(scnt), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; r_mem = 1'b0; exc = '0; epc = '0;
    m_left = 0; m_wd = 0; m_scnt = 0;
  endtask

  initial begin
    logic [31:0] codes [6];
    logic [31:0] e;
    codes[0] = 32'h1; codes[1] = 32'h8; codes[2] = 32'ha;
    codes[3] = 32'hd; codes[4] = 32'hc; codes[5] = 32'he;

    @(posedge clk); #1;
    do_reset();
    cycle(0, 0, 0, 0, 32'h0, 32'h0);

    // 1: long ex stall
    for (int i = 0; i < 34; i++) cycle(0, 0, 1, 0, 32'h0, 32'h0);
    cycle(0, 0, 0, 0, 32'h0, 32'h0);
    // 2: if + mem together
    cycle(1, 0, 0, 1, 32'h0, 32'h0);
    cycle(1, 1, 0, 0, 32'h0, 32'h0);
    cycle(0, 0, 0, 0, 32'h0, 32'h0);
    // 3: syscall with a load-use stall, then refill window
    cycle(0, 1, 0, 0, 32'h8, 32'h0);
    cycle(0, 0, 0, 0, 32'h0, 32'h0);
    cycle(0, 0, 0, 0, 32'h0, 32'h0);
    cycle(0, 0, 0, 0, 32'h0, 32'h0);
    // 4: eret redirect
    cycle(0, 0, 0, 0, 32'he, 32'h0000_1234);
    cycle(0, 0, 0, 0, 32'h0, 32'h0);
    cycle(0, 0, 0, 0, 32'h0, 32'h0);
    // 5: exception held through refill
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 32'hc, 32'h0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 32'h0, 32'h0);
    // 6: hung mem stall, watchdog (when enabled), reset mid-refill
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, 32'h0, 32'h0);
    do_reset();
    cycle(0, 0, 0, 0, 32'h0, 32'h0);

    // random traffic; the stall counter saturates along the way
    for (int i = 0; i < 400; i++) begin
      e = ($urandom_range(0, 11) == 0) ? codes[$urandom_range(0, 5)] : 32'h0;
      cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0), e, $urandom);
    end
    for (int i = 0; i < 80; i++) cycle(0, 0, 1, 0, 32'h0, 32'h0);
    cycle(0, 0, 0, 0, 32'h0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
